// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 register-init sequencer.
package ov7670_cfg_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StSend,
    StWait,
    StDelay,
    StDone
  } cfg_state_e;

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// Write-request handshake between the config sequencer and the SCCB write master.
interface ov7670_config_sequencer_if;
  import ov7670_cfg_pkg::*;

  logic              sccb_ready;
  logic              sccb_start;
  logic [ADDR_W-1:0] sccb_reg_addr;
  logic [7:0]        sccb_reg_data;
  logic              sccb_done;
  logic              sccb_nack;

  modport master (
    input  sccb_ready,
    input  sccb_done,
    input  sccb_nack,
    output sccb_start,
    output sccb_reg_addr,
    output sccb_reg_data
  );

  modport slave (
    output sccb_ready,
    output sccb_done,
    output sccb_nack,
    input  sccb_start,
    input  sccb_reg_addr,
    input  sccb_reg_data
  );

endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 init ROM and issues each entry as one SCCB register write,
// honouring the power-up delay and end-of-table sentinels.
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int unsigned RETRY_MAX    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [15:0]                rom_dout,
  ov7670_config_sequencer_if.master  sccb,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
  // +2 keeps the retry counter at least one bit wide when RETRY_MAX is 0.
  localparam int unsigned RW = $clog2(RETRY_MAX + 2);

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_data_q, reg_data_d;
  logic              err_q, err_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              send_pulse;
  logic              advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      err_q      <= 1'b0;
      retry_q    <= '0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      err_q      <= err_d;
      retry_q    <= retry_d;
      dly_q      <= dly_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    err_d      = err_q;
    retry_d    = retry_q;
    dly_d      = dly_q;
    send_pulse = 1'b0;
    advance    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          addr_d  = '0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (rom_dout == CFG_END) begin
          state_d = StDone;
        end else if (rom_dout == CFG_DELAY) begin
          dly_d   = DW'(DELAY_CYCLES - 1);
          state_d = StDelay;
        end else begin
          reg_addr_d = rom_dout[15:8];
          reg_data_d = rom_dout[7:0];
          retry_d    = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (sccb.sccb_ready) begin
          send_pulse = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (sccb.sccb_done) begin
          if (sccb.sccb_nack && (retry_q < RW'(RETRY_MAX))) begin
            retry_d = retry_q + 1'b1;
            state_d = StSend;
          end else begin
            if (sccb.sccb_nack) err_d = 1'b1;
            advance = 1'b1;
          end
        end
      end
      StDelay: begin
        if (dly_q == '0) advance = 1'b1;
        else             dly_d   = dly_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Last ROM slot finishes the table rather than wrapping to address 0.
    if (advance) begin
      if (addr_q == '1) begin
        state_d = StDone;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = StFetch;
      end
    end
  end

  assign rom_addr           = addr_q;
  assign sccb.sccb_start    = send_pulse;
  assign sccb.sccb_reg_addr = reg_addr_q;
  assign sccb.sccb_reg_data = reg_data_q;
  assign busy               = (state_q != StIdle) && (state_q != StDone);
  assign done               = (state_q == StDone);
  assign err                = err_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Scoreboard bench: expected writes are queued per scenario and popped as the
// sequencer issues sccb_start pulses against a ROM and SCCB responder model.
module tb_ov7670_config_sequencer;
  import ov7670_cfg_pkg::*;

  localparam int unsigned DelayCycles = 5;
  localparam int unsigned RetryMax    = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        busy, done, err;

  ov7670_config_sequencer_if sccb_bus ();

  ov7670_config_sequencer #(
    .DELAY_CYCLES (DelayCycles),
    .RETRY_MAX    (RetryMax)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .sccb     (sccb_bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Registered ROM read.
  logic [15:0] rom [256];
  always @(posedge clk) rom_dout <= rom[rom_addr];

  // SCCB responder: done 3 cycles after start; NACKs the first nack_budget writes per run.
  int nack_budget = 0;
  int nack_given  = 0;
  int pend        = 0;
  initial begin
    sccb_bus.sccb_done = 1'b0;
    sccb_bus.sccb_nack = 1'b0;
    sccb_bus.sccb_ready = 1'b1;
  end
  always @(posedge clk) begin
    sccb_bus.sccb_done <= 1'b0;
    sccb_bus.sccb_nack <= 1'b0;
    if (start) nack_given <= 0;
    if (sccb_bus.sccb_start) begin
      pend <= 2;
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        sccb_bus.sccb_done <= 1'b1;
        if (nack_given < nack_budget) begin
          sccb_bus.sccb_nack <= 1'b1;
          nack_given         <= nack_given + 1;
        end
      end
    end
  end

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  int          start_cyc[$];
  int          done_cyc[$];

  task automatic load_base_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
    rom[3] = 16'hFFFF;
  endtask

  // Pulses start, then tracks the run cycle by cycle (c = cycles after the start cycle).
  task automatic run_seq(input int budget, input int ready_hold, input int abort_after,
                         output int nstarts);
    logic [15:0] e;
    logic [15:0] got;
    bit          finished;
    finished = 1'b0;
    nstarts  = 0;
    start_cyc.delete();
    done_cyc.delete();
    @(posedge clk); #1;
    start = 1'b1;
    sccb_bus.sccb_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      sccb_bus.sccb_ready = !(c >= 3 && c < 3 + ready_hold);
      @(negedge clk);
      if (c == 1) begin
        total++;
        if ({busy, done, err} !== 3'b100) begin
          bad++;
          $display("FAIL after_start: busy/done/err=%b want 100", {busy, done, err});
        end
      end
      if (ready_hold > 0 && c >= 3 && c < 3 + ready_hold) begin
        total++;
        if ({sccb_bus.sccb_start, sccb_bus.sccb_reg_addr, sccb_bus.sccb_reg_data} !== 17'h01280) begin
          bad++;
          $display("FAIL hold_stable c=%0d: start=%b reg=%h data=%h want 0 12 80", c,
                   sccb_bus.sccb_start, sccb_bus.sccb_reg_addr, sccb_bus.sccb_reg_data);
        end
      end
      if (sccb_bus.sccb_done) done_cyc.push_back(c);
      if (sccb_bus.sccb_start) begin
        nstarts++;
        start_cyc.push_back(c);
        got = {sccb_bus.sccb_reg_addr, sccb_bus.sccb_reg_data};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected c=%0d: got %h want none", c, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL write_data c=%0d: got %h want %h", c, got, e);
          end
        end
        if (nstarts == abort_after) begin
          @(negedge clk);
          rst_n = 1'b0;
          #1;
          total++;
          if ({sccb_bus.sccb_start, rom_addr, sccb_bus.sccb_reg_addr, sccb_bus.sccb_reg_data,
               busy, done, err} !== 28'h0) begin
            bad++;
            $display("FAIL abort_reset: start=%b addr=%h reg=%h data=%h b/d/e=%b want all 0",
                     sccb_bus.sccb_start, rom_addr, sccb_bus.sccb_reg_addr,
                     sccb_bus.sccb_reg_data, {busy, done, err});
          end
          @(negedge clk);
          rst_n = 1'b1;
          finished = 1'b1;
          break;
        end
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL timeout: got no done within %0d cycles want done", budget);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_end(input string name, input int nstarts, input int want_starts,
                           input logic want_err);
    total++;
    if (nstarts != want_starts) begin
      bad++;
      $display("FAIL %s_starts: got %0d want %0d", name, nstarts, want_starts);
    end
    total++;
    if ({done, busy, err} !== {1'b1, 1'b0, want_err}) begin
      bad++;
      $display("FAIL %s_status: done/busy/err=%b want %b", name, {done, busy, err},
               {1'b1, 1'b0, want_err});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sccb_bus.sccb_start, rom_addr, sccb_bus.sccb_reg_addr, sccb_bus.sccb_reg_data,
         busy, done, err} !== 28'h0) begin
      bad++;
      $display("FAIL reset_state: start=%b addr=%h reg=%h data=%h b/d/e=%b want all 0",
               sccb_bus.sccb_start, rom_addr, sccb_bus.sccb_reg_addr,
               sccb_bus.sccb_reg_data, {busy, done, err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    load_base_rom();
    nack_budget = 0;
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    run_seq(300, 0, 0, n);
    check_end("basic", n, 2, 1'b0);
    total++;
    if (start_cyc.size() < 2 || done_cyc.size() < 1) begin
      bad++;
      $display("FAIL basic_timing: got %0d starts %0d dones want 2 and 1",
               start_cyc.size(), done_cyc.size());
    end else begin
      if (start_cyc[0] != 3) begin
        bad++;
        $display("FAIL first_write_latency: got %0d want 3", start_cyc[0]);
      end
      total++;
      // done -> FETCH, DECODE, 5 DELAY, FETCH, DECODE -> SEND
      if (start_cyc[1] - done_cyc[0] != 10) begin
        bad++;
        $display("FAIL delay_gap: got %0d want 10", start_cyc[1] - done_cyc[0]);
      end
    end
  endtask

  task automatic test_ready_hold();
    int n;
    load_base_rom();
    nack_budget = 0;
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    run_seq(400, 20, 0, n);
    check_end("ready_hold", n, 2, 1'b0);
    total++;
    if (start_cyc.size() < 1 || start_cyc[0] != 23) begin
      bad++;
      $display("FAIL ready_rise_pulse: got %0d want 23",
               (start_cyc.size() > 0) ? start_cyc[0] : -1);
    end
  endtask

  task automatic test_nack_all();
    int n;
    load_base_rom();
    nack_budget = 3;
    repeat (3) exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    run_seq(400, 0, 0, n);
    check_end("nack_all", n, 4, 1'b1);
  endtask

  task automatic test_nack_once();
    int n;
    load_base_rom();
    nack_budget = 1;
    repeat (2) exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    run_seq(400, 0, 0, n);
    check_end("nack_once", n, 3, 1'b0);
    nack_budget = 0;
  endtask

  task automatic test_full_rom();
    int n;
    for (int i = 0; i < 256; i++) begin
      rom[i] = {8'(i), 8'(i) ^ 8'h5A};
      exp_q.push_back(rom[i]);
    end
    nack_budget = 0;
    run_seq(4000, 0, 0, n);
    check_end("full_rom", n, 256, 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if ({rom_addr, done, sccb_bus.sccb_start} !== {8'hFF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL no_wrap: addr=%h done=%b start=%b want ff 1 0", rom_addr, done,
               sccb_bus.sccb_start);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    load_base_rom();
    nack_budget = 0;
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    run_seq(300, 0, 2, n);
    repeat (4) @(negedge clk);
    total++;
    if ({busy, done, sccb_bus.sccb_start} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle: busy/done/start=%b want 000", {busy, done, sccb_bus.sccb_start});
    end
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    run_seq(300, 0, 0, n);
    check_end("restart", n, 2, 1'b0);
    total++;
    if (start_cyc.size() < 1 || start_cyc[0] != 3) begin
      bad++;
      $display("FAIL restart_first_write: got %0d want 3",
               (start_cyc.size() > 0) ? start_cyc[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_hold();
    test_nack_all();
    test_nack_once();
    test_full_rom();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
